at86rf215_tx_sched: RTL and testbench

Packet-granular scheduler that shares the single AT86RF215 LVDS TX serializer between NUM_REQ AXI-Stream IQ requesters. It sits between the per-channel DMA/IQ sources and the serializer's 32-bit IQ stream input.
- Grants one requester per burst; a burst ends on tlast.
- Drives the serializer's mark_samp_rate and sync_bits from that requester's configuration.
- Enforces an idle guard gap so the serializer re-enters its zero-preamble phase.
- Aborts bursts on sustained serializer underflow.

---
 rtl/at86rf215_tx_sched.sv | 187 ++++++++++++++++++
 tb/tb_at86rf215_tx_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/at86rf215_tx_sched.sv
// Packet-granular scheduler sharing one AT86RF215 LVDS TX serializer among NUM_REQ AXI-Stream IQ requesters.
// Optional build macro AT86RF215_TX_SCHED_STRICT_PRIO_EN: strict lowest-index priority instead of round-robin.
module at86rf215_tx_sched #(
  parameter int NUM_REQ      = 2,
  parameter int GUARD_CYCLES = 40,
  parameter int CFG_SETTLE   = 4,
  parameter int UF_LIMIT     = 4
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic                   i_enable,
  input  logic [32*NUM_REQ-1:0]  i_s_axis_tdata,
  input  logic [NUM_REQ-1:0]     i_s_axis_tvalid,
  input  logic [NUM_REQ-1:0]     i_s_axis_tlast,
  output logic [NUM_REQ-1:0]     o_s_axis_tready,
  input  logic [5*NUM_REQ-1:0]   i_cfg_mark_samp_rate,
  input  logic [5*NUM_REQ-1:0]   i_cfg_sync_bits,
  output logic [31:0]            o_m_axis_tdata,
  output logic                   o_m_axis_tvalid,
  output logic                   o_m_axis_tlast,
  input  logic                   i_m_axis_tready,
  input  logic                   i_tx_underflow,
  output logic [4:0]             o_mark_samp_rate,
  output logic [4:0]             o_sync_bits,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_burst_done,
  output logic                   o_burst_abort,
  output logic [15:0]            o_burst_words
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("at86rf215_tx_sched: NUM_REQ must be within 2..4");
    end
  endgenerate

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (GUARD_CYCLES > CFG_SETTLE) ? GUARD_CYCLES : CFG_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int UF_W    = $clog2(UF_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_STREAM,
    S_ABORT,
    S_GUARD
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_grant;
  logic [4:0]         r_mark;
  logic [4:0]         r_sync;
  logic [15:0]        r_words;
  logic [CNT_W-1:0]   r_cnt;
  logic [UF_W-1:0]    r_uf;
  logic               r_done;
  logic               r_abort;

  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic [31:0]        w_sData;
  logic               w_sValid;
  logic               w_sLast;
  logic               w_fwd;
  logic               w_ufHit;
  logic               w_grantNow;

`ifndef AT86RF215_TX_SCHED_STRICT_PRIO_EN
  logic [IDX_W-1:0]   r_rrPtr;

  function automatic logic [IDX_W-1:0] wrapIdx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction
`endif

  // Winner search: descending loop so the lowest search offset is the last one to win.
  always_comb begin
    w_winner = '0;
`ifdef AT86RF215_TX_SCHED_STRICT_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (i_s_axis_tvalid[i]) w_winner = IDX_W'(i);
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (i_s_axis_tvalid[wrapIdx(int'(r_rrPtr), i)]) w_winner = wrapIdx(int'(r_rrPtr), i);
`endif
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  assign w_sData    = i_s_axis_tdata[32*int'(r_idx) +: 32];
  assign w_sValid   = i_s_axis_tvalid[r_idx];
  assign w_sLast    = i_s_axis_tlast[r_idx];
  assign w_ufHit    = i_tx_underflow && (r_uf == UF_W'(UF_LIMIT - 1));
  assign w_grantNow = (r_state == S_IDLE) && (w_next == S_CONFIG);

  always_comb begin
    w_next          = r_state;
    o_m_axis_tdata  = '0;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tlast  = 1'b0;
    o_s_axis_tready = '0;
    w_fwd           = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_enable && (|i_s_axis_tvalid)) w_next = S_CONFIG;
      S_CONFIG:
        if (r_cnt == CNT_W'(CFG_SETTLE - 1)) w_next = S_STREAM;
      S_STREAM: begin
        o_m_axis_tdata         = w_sData;
        o_m_axis_tvalid        = w_sValid;
        o_m_axis_tlast         = w_sLast;
        o_s_axis_tready[r_idx] = i_m_axis_tready;
        w_fwd                  = w_sValid && i_m_axis_tready;
        // A completing tlast beat takes precedence over an underflow abort.
        if (w_fwd && w_sLast) w_next = S_GUARD;
        else if (w_ufHit)     w_next = S_ABORT;
      end
      S_ABORT: begin
        o_s_axis_tready[r_idx] = 1'b1;
        if (w_sValid && w_sLast) w_next = S_GUARD;
      end
      S_GUARD:
        if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_grant <= '0;
      r_mark  <= '0;
      r_sync  <= '0;
      r_words <= '0;
      r_cnt   <= '0;
      r_uf    <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
`ifndef AT86RF215_TX_SCHED_STRICT_PRIO_EN
      r_rrPtr <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_STREAM) && (w_next == S_GUARD);
      r_abort <= (r_state == S_ABORT) && (w_next == S_GUARD);
      if (((r_state == S_CONFIG) || (r_state == S_GUARD)) && (w_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if ((r_state == S_STREAM) && i_tx_underflow && (w_next == S_STREAM))
        r_uf <= r_uf + 1'b1;
      else
        r_uf <= '0;
      if (w_grantNow) begin
        r_idx   <= w_winner;
        r_grant <= w_onehot;
        r_mark  <= i_cfg_mark_samp_rate[5*int'(w_winner) +: 5];
        r_sync  <= i_cfg_sync_bits[5*int'(w_winner) +: 5];
        r_words <= '0;
`ifndef AT86RF215_TX_SCHED_STRICT_PRIO_EN
        r_rrPtr <= wrapIdx(int'(w_winner), 1);
`endif
      end else if (w_fwd && (r_words != 16'hFFFF)) begin
        r_words <= r_words + 16'd1;
      end
      if (w_next == S_GUARD) r_grant <= '0;
    end
  end

  assign o_mark_samp_rate = r_mark;
  assign o_sync_bits      = r_sync;
  assign o_grant          = r_grant;
  assign o_busy           = (r_state != S_IDLE);
  assign o_burst_done     = r_done;
  assign o_burst_abort    = r_abort;
  assign o_burst_words    = r_words;

endmodule

// File: tb/tb_at86rf215_tx_sched.sv
// Self-checking bench for at86rf215_tx_sched: table-driven first burst plus hand-written multi-cycle sequences.
module tb_at86rf215_tx_sched;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [63:0] sTdata;
  logic [1:0]  sTvalid;
  logic [1:0]  sTlast;
  logic [1:0]  sTready;
  logic [9:0]  cfgMark;
  logic [9:0]  cfgSync;
  logic [31:0] mTdata;
  logic        mTvalid;
  logic        mTlast;
  logic        mTready;
  logic        txUnderflow;
  logic [4:0]  markSampRate;
  logic [4:0]  syncBits;
  logic [1:0]  grant;
  logic        busy;
  logic        burstDone;
  logic        burstAbort;
  logic [15:0] burstWords;

  int testsRun    = 0;
  int testsFailed = 0;

  at86rf215_tx_sched #(.NUM_REQ(2), .GUARD_CYCLES(40), .CFG_SETTLE(4), .UF_LIMIT(4)) dut (
    .i_aclk               (aclk),
    .i_areset             (areset),
    .i_enable             (enable),
    .i_s_axis_tdata       (sTdata),
    .i_s_axis_tvalid      (sTvalid),
    .i_s_axis_tlast       (sTlast),
    .o_s_axis_tready      (sTready),
    .i_cfg_mark_samp_rate (cfgMark),
    .i_cfg_sync_bits      (cfgSync),
    .o_m_axis_tdata       (mTdata),
    .o_m_axis_tvalid      (mTvalid),
    .o_m_axis_tlast       (mTlast),
    .i_m_axis_tready      (mTready),
    .i_tx_underflow       (txUnderflow),
    .o_mark_samp_rate     (markSampRate),
    .o_sync_bits          (syncBits),
    .o_grant              (grant),
    .o_busy               (busy),
    .o_burst_done         (burstDone),
    .o_burst_abort        (burstAbort),
    .o_burst_words        (burstWords)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        en;
    logic        valid0;
    logic        last0;
    logic [31:0] data0;
    logic [1:0]  expGrant;
    logic        expBusy;
    logic        expMValid;
    logic        expMLast;
    logic [31:0] expMData;
    logic [1:0]  expTready;
    logic        expDone;
    logic [15:0] expWords;
    logic [4:0]  expMark;
    logic [4:0]  expSync;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable        = v.en;
    sTvalid       = {1'b0, v.valid0};
    sTlast        = {1'b0, v.last0};
    sTdata[31:0]  = v.data0;
    sTdata[63:32] = '0;
    mTready       = 1'b1;
    txUnderflow   = 1'b0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge aclk);
    while (busy && n < 300) begin
      @(negedge aclk);
      n++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  // Drives one burst from requester req and checks its data, completion pulse and word count.
  task automatic runBurst(input string tag, input int req, input int nWords, input logic [31:0] base,
                          input logic [3:0] ufPat, input logic dropEn, input int cfgAt, input logic [4:0] newSync0);
    int beat = 0;
    int cyc = 0;
    int aborts = 0;
    logic [1:0] firstGrant = '0;
    logic [1:0] expGrant;
    expGrant = 2'b01 << req;
    while (beat < nWords && cyc < 300) begin
      tick();
      sTvalid             = '0;
      sTvalid[req]        = 1'b1;
      sTlast              = '0;
      sTlast[req]         = (beat == nWords - 1);
      sTdata[32*req +: 32] = base + 32'(beat);
      txUnderflow         = ufPat[cyc % 4];
      mTready             = 1'b1;
      if (dropEn && beat > 0) enable = 1'b0;
      if (cfgAt >= 0 && beat == cfgAt) cfgSync[4:0] = newSync0;
      @(negedge aclk);
      if (firstGrant == 2'b00) firstGrant = grant;
      if (burstAbort) aborts++;
      if (sTready[req]) begin
        checkOutput($sformatf("%s data%0d", tag, beat), mTdata, base + 32'(beat));
        beat++;
      end
      cyc++;
    end
    tick();
    sTvalid     = '0;
    sTlast      = '0;
    txUnderflow = 1'b0;
    @(negedge aclk);
    checkOutput({tag, " beats"}, 32'(beat), 32'(nWords));
    checkOutput({tag, " grant"}, 32'(firstGrant), 32'(expGrant));
    checkOutput({tag, " done"}, 32'(burstDone), 32'd1);
    checkOutput({tag, " aborts"}, 32'(aborts) + 32'(burstAbort), 32'd0);
    checkOutput({tag, " words"}, 32'(burstWords), 32'(nWords));
    enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic [1:0] gl[4];
    int gc;
    int nGrants;
    int nDone;
    int n;
    logic [1:0] prevGrant;
    logic [1:0] beatR;

    areset = 1'b1; enable = 1'b0; sTdata = '0; sTvalid = '0; sTlast = '0;
    mTready = 1'b1; txUnderflow = 1'b0;
    cfgMark = {5'h11, 5'h03};
    cfgSync = {5'h09, 5'h05};

    tbl[0] = '{1, 1, 0, 32'h11110000, 2'b00, 0, 0, 0, 32'h0,        2'b00, 0, 16'd0, 5'h00, 5'h00};
    tbl[1] = '{1, 1, 0, 32'h11110000, 2'b01, 1, 0, 0, 32'h0,        2'b00, 0, 16'd0, 5'h03, 5'h05};
    tbl[2] = '{1, 1, 0, 32'h11110000, 2'b01, 1, 0, 0, 32'h0,        2'b00, 0, 16'd0, 5'h03, 5'h05};
    tbl[3] = '{1, 1, 0, 32'h11110000, 2'b01, 1, 0, 0, 32'h0,        2'b00, 0, 16'd0, 5'h03, 5'h05};
    tbl[4] = '{1, 1, 0, 32'h11110000, 2'b01, 1, 0, 0, 32'h0,        2'b00, 0, 16'd0, 5'h03, 5'h05};
    tbl[5] = '{1, 1, 0, 32'h11110000, 2'b01, 1, 1, 0, 32'h11110000, 2'b01, 0, 16'd0, 5'h03, 5'h05};
    tbl[6] = '{1, 1, 0, 32'h11110001, 2'b01, 1, 1, 0, 32'h11110001, 2'b01, 0, 16'd1, 5'h03, 5'h05};
    tbl[7] = '{1, 1, 1, 32'h11110002, 2'b01, 1, 1, 1, 32'h11110002, 2'b01, 0, 16'd2, 5'h03, 5'h05};
    tbl[8] = '{1, 0, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,        2'b00, 1, 16'd3, 5'h03, 5'h05};
    tbl[9] = '{1, 0, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,        2'b00, 0, 16'd3, 5'h03, 5'h05};

    // Reset state
    @(negedge aclk);
    checkOutput("rst grant", 32'(grant), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst tready", 32'(sTready), 32'd0);
    checkOutput("rst mvalid", 32'(mTvalid), 32'd0);
    checkOutput("rst words", 32'(burstWords), 32'd0);
    checkOutput("rst sync", 32'(syncBits), 32'd0);
    tick();
    areset = 1'b0;

    // Test 1: table-driven single requester burst
    for (int k = 0; k < 10; k++) begin
      tick();
      applyStimulus(tbl[k]);
      @(negedge aclk);
      checkOutput($sformatf("t1[%0d] grant", k), 32'(grant), 32'(tbl[k].expGrant));
      checkOutput($sformatf("t1[%0d] busy", k), 32'(busy), 32'(tbl[k].expBusy));
      checkOutput($sformatf("t1[%0d] mvalid", k), 32'(mTvalid), 32'(tbl[k].expMValid));
      checkOutput($sformatf("t1[%0d] mlast", k), 32'(mTlast), 32'(tbl[k].expMLast));
      checkOutput($sformatf("t1[%0d] mdata", k), mTdata, tbl[k].expMData);
      checkOutput($sformatf("t1[%0d] tready", k), 32'(sTready), 32'(tbl[k].expTready));
      checkOutput($sformatf("t1[%0d] done", k), 32'(burstDone), 32'(tbl[k].expDone));
      checkOutput($sformatf("t1[%0d] words", k), 32'(burstWords), 32'(tbl[k].expWords));
      checkOutput($sformatf("t1[%0d] mark", k), 32'(markSampRate), 32'(tbl[k].expMark));
      checkOutput($sformatf("t1[%0d] sync", k), 32'(syncBits), 32'(tbl[k].expSync));
    end
    gc = 2;
    n = 0;
    while (n < 100) begin
      tick();
      @(negedge aclk);
      if (!busy) break;
      gc++;
      n++;
    end
    checkOutput("t1 guard cycles", 32'(gc), 32'd40);
    checkOutput("t1 idle grant", 32'(grant), 32'd0);
    checkOutput("t1 idle sync", 32'(syncBits), 32'h05);
    checkOutput("t1 idle mark", 32'(markSampRate), 32'h03);

    // Test 2: both requesters continuously valid, 2-word bursts
    areset = 1'b1;
    tick();
    areset = 1'b0;
    beatR = 2'b00; nGrants = 0; nDone = 0; prevGrant = 2'b00; n = 0;
    while (nDone < 4 && n < 800) begin
      tick();
      sTvalid = 2'b11;
      sTdata  = {32'h30000100 | 32'(beatR[1]), 32'h30000000 | 32'(beatR[0])};
      sTlast  = beatR;
      @(negedge aclk);
      if (grant != 2'b00 && prevGrant == 2'b00 && nGrants < 4) begin
        gl[nGrants] = grant;
        nGrants++;
      end
      prevGrant = grant;
      if (burstDone) begin
        nDone++;
        checkOutput($sformatf("t2 words%0d", nDone), 32'(burstWords), 32'd2);
      end
      beatR = beatR ^ sTready;
      n++;
    end
    sTvalid = '0; sTlast = '0;
    checkOutput("t2 grants seen", 32'(nGrants), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef AT86RF215_TX_SCHED_STRICT_PRIO_EN
      checkOutput($sformatf("t2 grant%0d", i), 32'(gl[i]), 32'd1);
`else
      checkOutput($sformatf("t2 grant%0d", i), 32'(gl[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
    end
    waitIdle("t2 idle");

    // Test 3: sustained underflow aborts req1 burst after two words
    tick();
    sTvalid = 2'b10; sTlast = 2'b00; sTdata[63:32] = 32'h22220000; txUnderflow = 1'b0;
    @(negedge aclk);
    n = 0;
    while (!sTready[1] && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("t3 stream", 32'(sTready[1]), 32'd1);
    tick();
    sTdata[63:32] = 32'h22220001;
    @(negedge aclk);
    checkOutput("t3 w1 grant", 32'(grant), 32'd2);
    tick();
    sTvalid = 2'b00; txUnderflow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checkOutput($sformatf("t3 uf%0d busy", i), 32'(busy), 32'd1);
      checkOutput($sformatf("t3 uf%0d abort", i), 32'(burstAbort), 32'd0);
      tick();
    end
    txUnderflow = 1'b0;
    for (int i = 2; i < 5; i++) begin
      if (i > 2) tick();
      sTvalid = 2'b10;
      sTdata[63:32] = 32'h22220000 + 32'(i);
      sTlast = (i == 4) ? 2'b10 : 2'b00;
      @(negedge aclk);
      checkOutput($sformatf("t3 flush%0d mvalid", i), 32'(mTvalid), 32'd0);
      checkOutput($sformatf("t3 flush%0d tready", i), 32'(sTready), 32'd2);
      checkOutput($sformatf("t3 flush%0d grant", i), 32'(grant), 32'd2);
      checkOutput($sformatf("t3 flush%0d abort", i), 32'(burstAbort), 32'd0);
    end
    tick();
    sTvalid = 2'b00; sTlast = 2'b00;
    @(negedge aclk);
    checkOutput("t3 abort pulse", 32'(burstAbort), 32'd1);
    checkOutput("t3 no done", 32'(burstDone), 32'd0);
    checkOutput("t3 words", 32'(burstWords), 32'd2);
    checkOutput("t3 grant off", 32'(grant), 32'd0);
    tick();
    @(negedge aclk);
    checkOutput("t3 abort end", 32'(burstAbort), 32'd0);
    waitIdle("t3 idle");

    // Test 4: intermittent underflow never reaches the limit; enable dropped mid-burst
    runBurst("t4", 0, 8, 32'h44440000, 4'b0111, 1'b1, -1, 5'h00);
    waitIdle("t4 idle");

    // Test 5: config change mid-burst only takes effect at the next grant
    runBurst("t5a", 0, 4, 32'h55550000, 4'b0000, 1'b0, 2, 5'h1A);
    checkOutput("t5a sync held", 32'(syncBits), 32'h05);
    waitIdle("t5a idle");
    checkOutput("t5a guard sync", 32'(syncBits), 32'h05);
    runBurst("t5b", 0, 2, 32'h55560000, 4'b0000, 1'b0, -1, 5'h00);
    checkOutput("t5b sync new", 32'(syncBits), 32'h1A);
    checkOutput("t5b mark", 32'(markSampRate), 32'h03);
    waitIdle("t5b idle");

    // enable low: requests pending but no grant issued
    tick();
    enable = 1'b0; sTvalid = 2'b11; sTlast = 2'b00;
    repeat (50) tick();
    @(negedge aclk);
    checkOutput("en0 grant", 32'(grant), 32'd0);
    checkOutput("en0 busy", 32'(busy), 32'd0);
    tick();
    sTvalid = 2'b00; enable = 1'b1;

    // Test 6: asynchronous reset in the middle of a stream
    tick();
    sTvalid = 2'b10; sTdata[63:32] = 32'h66660000;
    @(negedge aclk);
    n = 0;
    while (!sTready[1] && n < 20) begin
      @(negedge aclk);
      n++;
    end
    tick();
    sTdata[63:32] = 32'h66660001;
    @(negedge aclk);
    checkOutput("t6 pre words", 32'(burstWords), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("t6 rst grant", 32'(grant), 32'd0);
    checkOutput("t6 rst busy", 32'(busy), 32'd0);
    checkOutput("t6 rst tready", 32'(sTready), 32'd0);
    checkOutput("t6 rst mvalid", 32'(mTvalid), 32'd0);
    checkOutput("t6 rst mdata", mTdata, 32'd0);
    checkOutput("t6 rst words", 32'(burstWords), 32'd0);
    checkOutput("t6 rst sync", 32'(syncBits), 32'd0);
    checkOutput("t6 rst mark", 32'(markSampRate), 32'd0);
    sTvalid = 2'b00;
    tick();
    areset = 1'b0;
    runBurst("t6", 0, 2, 32'h66670000, 4'b0000, 1'b0, -1, 5'h00);
    checkOutput("t6 sync", 32'(syncBits), 32'h1A);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
